debug_trace_tx: RTL and testbench

DEBUG_TRACE_TX -- requirements
Module: debug_trace_tx

---
 rtl/trace_pkg.sv | 45 ++++
 rtl/trace_fifo.sv | 60 ++++++
 rtl/debug_trace_tx.sv | 180 ++++++++++++++++++
 tb/tb_debug_trace_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg -- shared types and constants for the debug trace transmitter.
//   trace_rec_t     : 69-bit retired-instruction record {pc, wr_reg, data}
//   TRACE_SYNC_BYTE : first byte of every serialized record (0xA5)
//   TRACE_REC_BYTES : bytes per serialized record (10)
//   tx_state_t      : UART transmit FSM states
//   trace_rec_byte  : returns byte <idx> of a record in wire order
package trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wr_reg;
    logic [31:0] data;
  } trace_rec_t;

  localparam logic [7:0] TRACE_SYNC_BYTE = 8'hA5;
  localparam int         TRACE_REC_BYTES = 10;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Wire order: sync, PC big-endian, zero-padded register, DATA big-endian.
  function automatic logic [7:0] trace_rec_byte(input trace_rec_t rec,
                                                input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = TRACE_SYNC_BYTE;
      4'd1:    b = rec.pc[31:24];
      4'd2:    b = rec.pc[23:16];
      4'd3:    b = rec.pc[15:8];
      4'd4:    b = rec.pc[7:0];
      4'd5:    b = {3'b000, rec.wr_reg};
      4'd6:    b = rec.data[31:24];
      4'd7:    b = rec.data[23:16];
      4'd8:    b = rec.data[15:8];
      4'd9:    b = rec.data[7:0];
      default: b = TRACE_SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo -- synchronous FIFO, DEPTH entries of WIDTH bits (DEPTH power of two).
// Ports:
//   clk, rst          : clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data     : write request and data; accepted when not full, or when
//                       a pop happens in the same cycle
//   pop               : read request; ignored while empty
//   rd_data           : head entry (valid while empty=0)
//   full, empty       : occupancy flags
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/debug_trace_tx.sv
// debug_trace_tx -- captures retired-instruction trace records into a FIFO and
// streams each one over a UART 8N1 line as 10 bytes:
//   A5, PC[31:24..7:0], {3'b000, reg}, DATA[31:24..7:0]
// Configuration macro: TRACE_ZERO_REG_EN -- when defined, records with
// trace_wr_reg = 0 are captured too; otherwise they are silently ignored
// (not counted as drops).
// Ports:
//   Clock, Reset     : system clock, synchronous active-high reset
//   trace_valid      : an instruction retired this cycle
//   trace_pc         : its PC
//   trace_wr_reg     : destination register
//   trace_wr_data    : value written
//   tx               : UART serial output, idle high
//   busy             : frame in flight or records still queued
//   overflow         : sticky, a record was dropped because the FIFO was full
//   drop_count       : number of dropped records, saturating at 255
//   state_dbg        : current transmit FSM state
// Handshake: a record is offered whenever trace_valid=1 on a rising edge; there
// is no back-pressure, so a record offered while the FIFO is full (and nothing
// leaves it that cycle) is lost and counted.
module debug_trace_tx
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [4:0]  trace_wr_reg,
  input  logic [31:0] trace_wr_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output tx_state_t   state_dbg
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(TRACE_REC_BYTES - 1);

  // Capture / FIFO
  logic       capture;
  logic       push;
  logic       pop;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  trace_rec_t wr_rec;
  trace_rec_t head_rec;

`ifdef TRACE_ZERO_REG_EN
  assign capture = trace_valid;
`else
  assign capture = trace_valid && (trace_wr_reg != 5'd0);
`endif

  assign wr_rec = '{pc: trace_pc, wr_reg: trace_wr_reg, data: trace_wr_data};
  assign push   = capture;
  assign drop   = capture && fifo_full && !pop;

  trace_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_rec),
    .rd_data (head_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Transmit FSM
  tx_state_t     state, state_n;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [3:0]    byte_idx, byte_idx_n;
  trace_rec_t    rec, rec_n;
  logic          bit_end;
  logic [7:0]    cur_byte;

  assign bit_end   = (clk_cnt == BIT_LAST);
  assign cur_byte  = trace_rec_byte(rec, byte_idx);
  assign state_dbg = state;
  assign busy      = (state != TX_IDLE) || !fifo_empty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= TX_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      rec      <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      rec      <= rec_n;
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    rec_n      = rec;
    pop        = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          rec_n      = head_rec;
          byte_idx_n = 4'd0;
          clk_cnt_n  = '0;
          state_n    = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = 3'd0;
          state_n   = TX_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          if (bit_idx == 3'd7) state_n = TX_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          // Bytes of one record go back to back; next record needs a pass through IDLE.
          if (byte_idx < BYTE_LAST) begin
            byte_idx_n = byte_idx + 4'd1;
            state_n    = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      TX_START: tx = 1'b0;
      TX_DATA:  tx = cur_byte[bit_idx];
      default:  tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_debug_trace_tx.sv
// tb_debug_trace_tx -- randomized and directed bench for debug_trace_tx.
// Expected bytes are queued when a record is offered; an independent UART
// receiver decodes tx and pops/compares them.
module tb_debug_trace_tx;
  import trace_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  // Line time of one record: 10 bytes x 10 bits x CPB clocks.
  localparam int FRAME = 10 * 10 * CPB;
`ifdef TRACE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        Reset;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_wr_reg;
  logic [31:0] trace_wr_data;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [7:0]  drop_count;
  tx_state_t   state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  debug_trace_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock         (clk),
    .Reset         (Reset),
    .trace_valid   (trace_valid),
    .trace_pc      (trace_pc),
    .trace_wr_reg  (trace_wr_reg),
    .trace_wr_data (trace_wr_data),
    .tx            (tx),
    .busy          (busy),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int         tests       = 0;
  int         errors      = 0;
  int         reset_epoch = 0;

  // Reference model: record i leaves the FIFO at edge
  //   max(capture_edge + 1, previous_pop + FRAME + 1)
  // and occupies it between its capture and that edge.
  int         edge_n      = 0;
  int         pend_pop[$];
  int         last_pop    = -100000;
  int         model_drops = 0;
  bit         model_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_capture(input int e, input logic [31:0] pc,
                               input logic [4:0] r, input logic [31:0] d);
    int occ;
    bit pop_now;
    int p;
    while (pend_pop.size() > 0 && pend_pop[0] < e) void'(pend_pop.pop_front());
    occ     = pend_pop.size();
    pop_now = (occ > 0) && (pend_pop[0] == e);
    if (occ < DEPTH || pop_now) begin
      p = (e + 1 > last_pop + FRAME + 1) ? e + 1 : last_pop + FRAME + 1;
      last_pop = p;
      pend_pop.push_back(p);
      exp_q.push_back(8'hA5);
      exp_q.push_back(pc[31:24]);
      exp_q.push_back(pc[23:16]);
      exp_q.push_back(pc[15:8]);
      exp_q.push_back(pc[7:0]);
      exp_q.push_back({3'b000, r});
      exp_q.push_back(d[31:24]);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end else begin
      model_ovf = 1'b1;
      if (model_drops < 255) model_drops++;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Present inputs for one rising edge, then return #1 after it.
  task automatic tick(input bit v, input logic [31:0] pc, input logic [4:0] r,
                      input logic [31:0] d);
    trace_valid   = v;
    trace_pc      = pc;
    trace_wr_reg  = r;
    trace_wr_data = d;
    edge_n++;
    if (v && !Reset && (r != 5'd0 || ZERO_EN)) model_capture(edge_n, pc, r, d);
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 5'd0, 32'd0);
  endtask

  task automatic do_reset(input int n);
    Reset = 1'b1;
    reset_epoch++;
    idle(n);
    Reset = 1'b0;
    pend_pop.delete();
    last_pop    = -100000;
    model_drops = 0;
    model_ovf   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      idle(1);
      n++;
    end
    check({name, "_busy_clears"}, {31'd0, busy}, 32'd0);
    idle(3);
    check({name, "_all_bytes_seen"}, exp_q.size(), 32'd0);
  endtask

  task automatic rand_rec(input bit v, input bit allow_zero);
    logic [4:0] r;
    if (allow_zero && $urandom_range(0, 3) == 0) r = 5'd0;
    else r = 5'($urandom_range(1, 31));
    tick(v, $urandom, r, $urandom);
  endtask

  // ---------------- monitor: UART receiver ----------------
  initial begin : monitor
    logic [7:0] b;
    logic       stop_bit;
    logic [7:0] e;
    int         ep;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ep = reset_epoch;
        b  = 8'd0;
        repeat (CPB + CPB / 2) @(negedge clk);
        b[0] = tx;
        for (int k = 1; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = tx;
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        // A byte cut short by reset is not a real byte.
        if (ep == reset_epoch) begin
          if (exp_q.size() == 0) begin
            tests++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h expected none (t=%0t)", b, $time);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", {24'd0, b}, {24'd0, e});
            check("stop_bit", {31'd0, stop_bit}, 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n;
    int bad;
    Reset = 1'b1;
    trace_valid = 1'b0;
    trace_pc = 32'd0;
    trace_wr_reg = 5'd0;
    trace_wr_data = 32'd0;

    // Reset held two cycles.
    do_reset(2);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_count", {24'd0, drop_count}, 32'd0);

    // Single record: exact latency and busy window.
    tick(1'b1, 32'h0000_0008, 5'd9, 32'h0000_002A);
    check("cap_busy_high", {31'd0, busy}, 32'd1);
    check("cap_tx_still_idle", {31'd0, tx}, 32'd1);
    idle(1);
    check("start_bit_next_cycle", {31'd0, tx}, 32'd0);
    n = 1;
    while (busy !== 1'b0 && n < 1000) begin
      idle(1);
      n++;
    end
    check("busy_cycles", n, FRAME + 1);
    idle(3);
    check("single_all_bytes_seen", exp_q.size(), 32'd0);

    // Record writing register 0.
    tick(1'b1, 32'h0000_0100, 5'd0, 32'h1234_5678);
`ifdef TRACE_ZERO_REG_EN
    wait_idle("zero_reg", 2000);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      idle(1);
    end
    check("zero_reg_filtered", bad, 32'd0);
    check("zero_reg_no_drop", {24'd0, drop_count}, 32'd0);
`endif

    // Six back-to-back records into a four-deep FIFO.
    for (int i = 1; i <= 6; i++) tick(1'b1, $urandom, 5'(i), $urandom);
    check("burst_overflow", {31'd0, overflow}, 32'd1);
    check("burst_drop_count", {24'd0, drop_count}, 32'd1);
    wait_idle("burst", 3000);

    // Reset in the middle of byte index 3.
    tick(1'b1, 32'h1122_3344, 5'd7, 32'h5566_7788);
    idle(135);
    check("bytes_before_reset", exp_q.size(), 32'd7);
    do_reset(1);
    exp_q.delete();
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_overflow", {31'd0, overflow}, 32'd0);
    check("abort_drop_count", {24'd0, drop_count}, 32'd0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      idle(1);
    end
    check("abort_no_resume", bad, 32'd0);
    tick(1'b1, 32'hCAFE_0004, 5'd31, 32'hDEAD_BEEF);
    wait_idle("after_abort", 2000);

    // Random traffic, dense enough to fill the FIFO at times.
    for (int i = 0; i < 3000; i++) rand_rec($urandom_range(0, 99) < 2, 1'b1);
    check("rand_overflow", {31'd0, overflow}, {31'd0, model_ovf});
    check("rand_drop_count", {24'd0, drop_count}, model_drops);
    wait_idle("rand", 6000);

    // Saturation: FIFO held full for 300+ offers.
    do_reset(2);
    for (int i = 0; i < 310; i++) rand_rec(1'b1, 1'b0);
    check("sat_drop_count", {24'd0, drop_count}, 32'd255);
    check("sat_overflow", {31'd0, overflow}, 32'd1);
    wait_idle("sat", 3000);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
